uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Shares one UART transmitter among NUM_REQ byte-stream requesters. Packets are granted round-robin and locked per packet. The block sits between client logic (debug printers, status reporters) and a uart_tx instance. It drives that transmitter's valid and byte inputs and paces itself off the transmitter's done level. Each accepted byte is held stable until the transmitter has latched it.

Parameters:
NUM_REQ, 4, number of requesters (2..8).
GAP_TIMEOUT, 1024, cycles the granted requester may leave i_ReqValid low mid-packet before the grant is revoked; 0 disables the timeout.
GAP_W, 16, width of the gap counter; must hold GAP_TIMEOUT.

Ports:
i_SysClock  in  1  system clock; all logic is on its rising edge.
i_Reset  in  1  synchronous reset, active-high.
i_ReqValid  in  NUM_REQ  per-requester byte valid.
i_ReqData  in  8*NUM_REQ  per-requester byte; requester k uses bits [8k+7:8k].
i_ReqLast  in  NUM_REQ  marks the final byte of a packet.
o_ReqReady  out  NUM_REQ  per-requester ready; a byte transfers when valid and ready are both high.
o_Grant  out  NUM_REQ  one-hot current owner; all zero when nobody owns the transmitter.
o_Busy  out  1  high in any state other than ARB.
o_TxValid  out  1  to uart_tx i_TxValid.
o_TxByte  out  8  to uart_tx i_TxByte; registered.
i_TxDone  in  1  from uart_tx o_TxDone; high means the transmitter is idle or in its stop bit.

Behaviour:
- Reset values: state ARB, o_Grant 0, o_ReqReady 0, o_TxValid 0, o_TxByte 8'hFF, o_Busy 0, round-robin pointer 0, gap counter 0.
- Reset does not abort a downstream frame in flight. After reset, SEND waits for i_TxDone=1 before issuing.
- States: ARB, LOAD, SEND, WAIT_START, WAIT_STOP.
- ARB:
  - If any i_ReqValid is high, grant the first requester at index >= pointer, searching cyclically.
  - Register o_Grant, set pointer to grantee+1 mod NUM_REQ, go to LOAD.
  - Otherwise stay in ARB.
  - Arbitration costs one cycle.
- LOAD:
  - o_ReqReady[g] = 1 combinationally for grantee g; all other ready bits stay 0.
  - On i_ReqValid[g]: capture byte into o_TxByte, capture last flag, clear the gap counter, go to SEND.
  - Otherwise increment the gap counter. When it reaches GAP_TIMEOUT (if nonzero): clear o_Grant and go to ARB. The revoked packet is simply truncated.
- SEND:
  - o_TxValid = 1 (registered, asserted the cycle after the LOAD accept).
  - Issue is the cycle with o_TxValid and i_TxDone both high. Next cycle o_TxValid = 0, go to WAIT_START.
- WAIT_START:
  - Stay while i_TxDone = 1 (the transmitter is entering its start bit).
  - Go to WAIT_STOP when i_TxDone = 0.
  - o_TxByte is held unchanged here because the transmitter latches the byte throughout its start bit.
- WAIT_STOP:
  - Stay while i_TxDone = 0.
  - On i_TxDone = 1: if the last flag is set, clear o_Grant and go to ARB; else go to LOAD.
  - The next byte is therefore offered during the transmitter's stop bit, so a packet streams back-to-back with no extra idle bit.
- Packet lock: other requesters get no ready while a packet is owned, even if valid.
- A grantee may deassert valid mid-packet; only the gap timeout can revoke it.
- Simultaneous requests: the lowest index at or after the pointer wins. With pointer wrap, grantee NUM_REQ-1 moves the pointer to 0.
- Single-byte packets (last on the first byte) are legal: the path is ARB→LOAD→SEND→WAIT_START→WAIT_STOP→ARB.
- Invariants:
  - o_Grant is zero or one-hot.
  - At most one o_ReqReady bit is high, and only in LOAD.
  - o_TxValid is never high outside SEND.
  - o_TxByte changes only on a LOAD accept.

Test Plan:
- Single requester 0 sends 3 bytes 0x55, 0xA3, 0x0F (last on 0x0F) into a real uart_tx, 50 MHz / 115200 baud. The serial monitor decodes exactly 55 A3 0F. Stop bit to next start bit is a gap of one bit period. o_Grant returns to 0 after the 0x0F stop.
- Requesters 0, 1 and 2 each post a 2-byte packet in the same cycle after reset. Grant order is 0, 1, 2. Bytes are never interleaved. A further request from 0 during packet 2 waits until packet 2's last byte completes.
- Pointer fairness: requester 3 is granted first, then 0 and 3 request together. 0 wins. On the next round with 0 and 3 requesting, 3 wins.
- Gap timeout, GAP_TIMEOUT=8: requester 1 sends 1 byte without last, then drops valid. In LOAD, o_Grant goes to 0 after 8 cycles. A pending requester 2 is granted on the following ARB cycle.
- Stub transmitter holding i_TxDone low for 20 cycles after issue. o_TxByte stays stable and o_ReqReady stays 0 until i_TxDone rises. o_TxValid is a single-cycle pulse per byte when i_TxDone is already high.
- i_Reset asserted in WAIT_STOP while the stub has i_TxDone low. The next cycle all outputs are at reset values. A new request is not issued (o_TxValid stays 0) until i_TxDone=1.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and transmitter-side signals of the UART transmit arbiter.
// The master modport is the arbiter; the slave modport is the clients plus uart_tx.
interface uart_tx_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   i_ReqValid;
    logic [8*NUM_REQ-1:0] i_ReqData;
    logic [NUM_REQ-1:0]   i_ReqLast;
    logic [NUM_REQ-1:0]   o_ReqReady;
    logic [NUM_REQ-1:0]   o_Grant;
    logic                 o_Busy;
    logic                 o_TxValid;
    logic [7:0]           o_TxByte;
    logic                 i_TxDone;

    modport master (
        input  i_ReqValid, i_ReqData, i_ReqLast, i_TxDone,
        output o_ReqReady, o_Grant, o_Busy, o_TxValid, o_TxByte
    );

    modport slave (
        output i_ReqValid, i_ReqData, i_ReqLast, i_TxDone,
        input  o_ReqReady, o_Grant, o_Busy, o_TxValid, o_TxByte
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked sharing of one uart_tx among NUM_REQ byte-stream requesters.
// Paces off the transmitter's done level so a packet streams with no idle bit between bytes.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned GAP_TIMEOUT = 1024,
    parameter int unsigned GAP_W       = 16
) (
    input logic               i_SysClock,
    input logic               i_Reset,
    uart_tx_arbiter_if.master bus_io
);
    localparam int unsigned PtrW = $clog2(NUM_REQ);

    typedef enum logic [2:0] {
        StArb,
        StLoad,
        StSend,
        StWaitStart,
        StWaitStop
    } state_e;

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [PtrW-1:0]    ptr_q, ptr_d;
    logic [PtrW-1:0]    gidx_q, gidx_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               last_q, last_d;
    logic               tx_valid_q, tx_valid_d;
    logic [7:0]         tx_byte_q, tx_byte_d;

    logic               found;
    logic [PtrW-1:0]    cand;
    logic               load_accept;

    assign load_accept = (state_q == StLoad) && bus_io.i_ReqValid[gidx_q];

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        gidx_d     = gidx_q;
        gap_d      = gap_q;
        last_d     = last_q;
        tx_valid_d = tx_valid_q;
        tx_byte_d  = tx_byte_q;
        found      = 1'b0;
        cand       = '0;

        unique case (state_q)
            StArb: begin
                // Cyclic search starting at the pointer; first hit wins.
                for (int unsigned i = 0; i < NUM_REQ; i++) begin
                    cand = PtrW'((32'(ptr_q) + i) % NUM_REQ);
                    if (!found && bus_io.i_ReqValid[cand]) begin
                        found         = 1'b1;
                        grant_d       = '0;
                        grant_d[cand] = 1'b1;
                        gidx_d        = cand;
                        ptr_d         = PtrW'((32'(cand) + 1) % NUM_REQ);
                        gap_d         = '0;
                        state_d       = StLoad;
                    end
                end
            end
            StLoad: begin
                if (load_accept) begin
                    tx_byte_d  = bus_io.i_ReqData[{gidx_q, 3'b000} +: 8];
                    last_d     = bus_io.i_ReqLast[gidx_q];
                    gap_d      = '0;
                    tx_valid_d = 1'b1;
                    state_d    = StSend;
                end else if (GAP_TIMEOUT != 0) begin
                    gap_d = gap_q + 1'b1;
                    if (gap_d == GAP_W'(GAP_TIMEOUT)) begin
                        grant_d = '0;
                        gap_d   = '0;
                        state_d = StArb;
                    end
                end
            end
            StSend: begin
                if (bus_io.i_TxDone) begin
                    tx_valid_d = 1'b0;
                    state_d    = StWaitStart;
                end
            end
            StWaitStart: begin
                // Done stays high while the transmitter is still latching the byte.
                if (!bus_io.i_TxDone) begin
                    state_d = StWaitStop;
                end
            end
            StWaitStop: begin
                if (bus_io.i_TxDone) begin
                    if (last_q) begin
                        grant_d = '0;
                        state_d = StArb;
                    end else begin
                        state_d = StLoad;
                    end
                end
            end
            default: state_d = StArb;
        endcase
    end

    always_ff @(posedge i_SysClock) begin
        if (i_Reset) begin
            state_q    <= StArb;
            grant_q    <= '0;
            ptr_q      <= '0;
            gidx_q     <= '0;
            gap_q      <= '0;
            last_q     <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_byte_q  <= 8'hFF;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            gidx_q     <= gidx_d;
            gap_q      <= gap_d;
            last_q     <= last_d;
            tx_valid_q <= tx_valid_d;
            tx_byte_q  <= tx_byte_d;
        end
    end

    assign bus_io.o_ReqReady = (state_q == StLoad) ? grant_q : '0;
    assign bus_io.o_Grant    = grant_q;
    assign bus_io.o_Busy     = (state_q != StArb);
    assign bus_io.o_TxValid  = tx_valid_q;
    assign bus_io.o_TxByte   = tx_byte_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: queued requester streams, a stub uart_tx, and a
// monitor that checks every issued byte and owner against hand-computed expectations.
module tb_uart_tx_arbiter;
    localparam int unsigned NReq  = 4;
    localparam int unsigned GapTo = 8;

    typedef struct packed {
        logic [7:0] gnt;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(NReq)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ    (NReq),
        .GAP_TIMEOUT(GapTo),
        .GAP_W      (16)
    ) dut (
        .i_SysClock(clk),
        .i_Reset   (rst),
        .bus_io    (bus)
    );

    int          total = 0;
    int          bad = 0;
    int          stub_len = 6;
    exp_t        exp_q[$];
    logic [8:0]  rq[NReq][$];
    logic [NReq-1:0] hs_drv;
    logic        infl;
    logic        prev_issue;
    logic [7:0]  infl_byte;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    task automatic send(input int unsigned who, input logic [7:0] d, input logic last);
        rq[who].push_back({last, d});
    endtask

    task automatic expect_byte(input int unsigned who, input logic [7:0] d);
        exp_t e;
        e.gnt  = 8'(1 << who);
        e.data = d;
        exp_q.push_back(e);
    endtask

    function automatic logic rq_empty();
        for (int k = 0; k < NReq; k++) if (rq[k].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic check_reset_vals(input string name);
        check({name, "_grant"}, bus.o_Grant, 0);
        check({name, "_ready"}, bus.o_ReqReady, 0);
        check({name, "_txvalid"}, bus.o_TxValid, 0);
        check({name, "_txbyte"}, bus.o_TxByte, 8'hFF);
        check({name, "_busy"}, bus.o_Busy, 0);
    endtask

    task automatic reset_dut();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_vals("rst");
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        logic ok;
        ok = 1'b0;
        for (int n = 0; n < budget && !ok; n++) begin
            @(negedge clk);
            ok = (exp_q.size() == 0) && (bus.o_Grant == 0) && !bus.o_Busy && bus.i_TxDone
                 && rq_empty();
        end
        check({name, "_idle"}, ok, 1);
    endtask

    // Requester model: each queue presents its head byte; pops on a valid&ready edge.
    initial begin
        bus.i_ReqValid = '0;
        bus.i_ReqData  = '0;
        bus.i_ReqLast  = '0;
        forever begin
            @(negedge clk);
            hs_drv = bus.i_ReqValid & bus.o_ReqReady;
            @(posedge clk);
            #1;
            for (int k = 0; k < NReq; k++) begin
                if (hs_drv[k] && !rst) void'(rq[k].pop_front());
                if (rq[k].size() > 0) begin
                    bus.i_ReqValid[k]       = 1'b1;
                    bus.i_ReqData[k*8 +: 8] = rq[k][0][7:0];
                    bus.i_ReqLast[k]        = rq[k][0][8];
                end else begin
                    bus.i_ReqValid[k] = 1'b0;
                    bus.i_ReqLast[k]  = 1'b0;
                end
            end
        end
    end

    // Stub uart_tx: done drops the cycle after issue and stays low for stub_len cycles.
    initial begin
        bus.i_TxDone = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.o_TxValid && bus.i_TxDone && !rst) begin
                @(posedge clk);
                #1 bus.i_TxDone = 1'b0;
                repeat (stub_len) @(posedge clk);
                #1 bus.i_TxDone = 1'b1;
            end
        end
    end

    // Monitor: pops the scoreboard on each issue and checks hold/lock behaviour.
    initial begin
        infl       = 1'b0;
        prev_issue = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                infl       = 1'b0;
                prev_issue = 1'b0;
            end else begin
                check("grant_onehot0", 32'($onehot0(bus.o_Grant)), 1);
                check("ready_grantee_only",
                      32'(((bus.o_ReqReady & ~bus.o_Grant) == 0) && $onehot0(bus.o_ReqReady)), 1);
                check("txvalid_needs_busy", 32'(!bus.o_TxValid || bus.o_Busy), 1);
                if (prev_issue) check("txvalid_pulse", bus.o_TxValid, 0);
                if (infl && !bus.i_TxDone) begin
                    check("txbyte_hold", bus.o_TxByte, infl_byte);
                    check("ready_while_tx", bus.o_ReqReady, 0);
                end
                if (infl && bus.i_TxDone) infl = 1'b0;
                prev_issue = 1'b0;
                if (bus.o_TxValid && bus.i_TxDone) begin
                    prev_issue = 1'b1;
                    infl       = 1'b1;
                    infl_byte  = bus.o_TxByte;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL sb_unexpected: got byte %h grant %b, want no issue",
                                 bus.o_TxByte, bus.o_Grant);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("sb_grant", bus.o_Grant, e.gnt);
                        check("sb_byte", bus.o_TxByte, e.data);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want test end");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_vals("por");
        @(posedge clk); #1 rst = 1'b0;

        // Single requester, three-byte packet.
        send(0, 8'h55, 0); send(0, 8'hA3, 0); send(0, 8'h0F, 1);
        expect_byte(0, 8'h55); expect_byte(0, 8'hA3); expect_byte(0, 8'h0F);
        wait_idle(300, "t1");

        // Three simultaneous packets, plus a late request from 0 during packet 2.
        reset_dut();
        send(0, 8'h10, 0); send(0, 8'h11, 1);
        send(1, 8'h20, 0); send(1, 8'h21, 1);
        send(2, 8'h30, 0); send(2, 8'h31, 1);
        expect_byte(0, 8'h10); expect_byte(0, 8'h11);
        expect_byte(1, 8'h20); expect_byte(1, 8'h21);
        expect_byte(2, 8'h30); expect_byte(2, 8'h31);
        seen = 1'b0;
        for (int n = 0; n < 400 && !seen; n++) begin
            @(negedge clk);
            seen = (bus.o_Grant == 4'b0100);
        end
        check("t2_grant2_seen", seen, 1);
        @(posedge clk); #1;
        send(0, 8'h40, 1);
        expect_byte(0, 8'h40);
        wait_idle(400, "t2");

        // Pointer fairness between 0 and 3.
        reset_dut();
        send(3, 8'h33, 1);
        expect_byte(3, 8'h33);
        wait_idle(200, "t3a");
        send(0, 8'hA0, 1); send(0, 8'hA1, 1); send(3, 8'hB3, 1);
        expect_byte(0, 8'hA0); expect_byte(3, 8'hB3); expect_byte(0, 8'hA1);
        wait_idle(400, "t3b");

        // Gap timeout: requester 1 stalls mid-packet, requester 2 waits.
        reset_dut();
        send(1, 8'h71, 0); send(2, 8'h72, 1);
        expect_byte(1, 8'h71); expect_byte(2, 8'h72);
        seen = 1'b0;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge clk);
            seen = (exp_q.size() == 1);
        end
        check("t4_first_issue", seen, 1);
        seen = 1'b0;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge clk);
            seen = bus.o_ReqReady[1];
        end
        check("t4_reload", seen, 1);
        for (int i = 2; i <= GapTo; i++) begin
            @(negedge clk);
            check("t4_hold", bus.o_Grant, 4'b0010);
        end
        @(negedge clk);
        check("t4_revoked", bus.o_Grant, 0);
        @(negedge clk);
        check("t4_next_grant", bus.o_Grant, 4'b0100);
        wait_idle(200, "t4");

        // Slow transmitter: done held low 20 cycles per byte.
        reset_dut();
        stub_len = 20;
        send(2, 8'hC1, 0); send(2, 8'hC2, 1);
        expect_byte(2, 8'hC1); expect_byte(2, 8'hC2);
        wait_idle(400, "t5");

        // Reset in WAIT_STOP with the transmitter still busy.
        reset_dut();
        send(0, 8'hD0, 1);
        expect_byte(0, 8'hD0);
        seen = 1'b0;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge clk);
            seen = (exp_q.size() == 0);
        end
        check("t6_issue", seen, 1);
        repeat (6) @(negedge clk);
        check("t6_busy_before", bus.o_Busy, 1);
        check("t6_done_low", bus.i_TxDone, 0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_vals("t6");
        @(posedge clk); #1 rst = 1'b0;
        send(1, 8'hE1, 1);
        expect_byte(1, 8'hE1);
        repeat (5) @(negedge clk);
        check("t6_done_still_low", bus.i_TxDone, 0);
        check("t6_byte_loaded", bus.o_TxByte, 8'hE1);
        check("t6_grant_held", bus.o_Grant, 4'b0010);
        wait_idle(300, "t6");

        check("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
